// File: rtl/softmax_norm.sv
// softmax_norm: buffers NUM_CLASSES exp values, sums them, then streams x[i]/sum in Q(FRACTION)
// Ports:
//   clk, rst (async, active-low)
//   softmax_ready_in/valid_in/data_in    : input stream, accepted only while accumulating
//   softmax_ready_out/valid_out/data_out : output stream of quotients
//   softmax_last_out                     : flags the final element of a vector
module softmax_norm #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACTION    = 8,
    parameter int NUM_CLASSES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  softmax_ready_in,
    input  logic                  softmax_valid_in,
    input  logic [DATA_WIDTH-1:0] softmax_data_in,
    input  logic                  softmax_ready_out,
    output logic                  softmax_valid_out,
    output logic [DATA_WIDTH-1:0] softmax_data_out,
    output logic                  softmax_last_out
);
    localparam int SUM_WIDTH = DATA_WIDTH + $clog2(NUM_CLASSES);
    localparam int IDX_W     = $clog2(NUM_CLASSES);
    localparam int QB        = DATA_WIDTH + FRACTION;
    localparam int CNT_W     = $clog2(QB);
    typedef enum logic [1:0] {ACCUM, DIV, OUT} state_e;
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d, rem_q, rem_d;
    logic [QB-1:0]         quo_q, quo_d, num;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d, last_q, last_d, last_idx, ge;
    logic [DATA_WIDTH-1:0] data_q, data_d, result;
    logic [SUM_WIDTH:0]    rem_sh, rem_nx;
    logic [DATA_WIDTH-1:0] mem_q [NUM_CLASSES];
    assign softmax_ready_in  = state_q == ACCUM;
    assign softmax_valid_out = valid_q;
    assign softmax_data_out  = data_q;
    assign softmax_last_out  = last_q;
    assign last_idx = index_q == IDX_W'(NUM_CLASSES - 1);
    // Numerator bits are consumed MSB first; cnt_q counts down so it indexes num directly.
    assign num    = {mem_q[index_q], {FRACTION{1'b0}}};
    assign rem_sh = {rem_q, num[cnt_q]};
    assign ge     = rem_sh >= {1'b0, sum_q};
    assign rem_nx = ge ? rem_sh - {1'b0, sum_q} : rem_sh;
    // A zero sum makes every trial subtraction succeed; the result is forced to 0 instead.
    assign result = (sum_q == '0) ? '0 : (|quo_q[QB-1:DATA_WIDTH]) ? '1 : quo_q[DATA_WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        case (state_q)
            ACCUM: if (softmax_valid_in) begin
                sum_d   = sum_q + SUM_WIDTH'(softmax_data_in);
                index_d = last_idx ? '0 : index_q + IDX_W'(1);
                if (last_idx) begin
                    state_d = DIV;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(QB - 1);
                end
            end
            DIV: begin
                rem_d = rem_nx[SUM_WIDTH-1:0];
                quo_d = {quo_q[QB-2:0], ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = OUT;
            end
            OUT: if (!valid_q) begin
                // First OUT cycle captures the finished quotient into the output register.
                valid_d = 1'b1;
                data_d  = result;
                last_d  = last_idx;
            end else if (softmax_ready_out) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (last_q) begin
                    sum_d   = '0;
                    index_d = '0;
                    state_d = ACCUM;
                end else begin
                    index_d = index_q + IDX_W'(1);
                    state_d = DIV;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(QB - 1);
                end
            end
            default: state_d = ACCUM;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACCUM;
            index_q <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
    always_ff @(posedge clk) begin
        if (softmax_ready_in && softmax_valid_in) mem_q[index_q] <= softmax_data_in;
    end
endmodule
